// File: rtl/transpose_network_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : transpose_network_sequencer
// Purpose  : Sequences a STAGES-deep pipeline of single-switch transpose
//            stages that moves one N_ROWS x N_ROWS matrix, one row per beat.
//            Accepts rows from the source, drives the per-stage swap select,
//            the global stage advance enable and the output valid/last flags
//            aligned with the network output register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_ROWS     rows (beats) per matrix, power of two, >= 2
//   STAGES     number of switch stages, equal to log2(N_ROWS)
//   STAGE_LAT  register cycles per switch stage (>= 1)
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   start      request to begin a new matrix
//   in_valid   source presents a row
//   in_ready   sequencer accepts a row this cycle
//   out_ready  sink accepts network output
//   out_valid  network output row valid
//   out_last   output row is the final row of its matrix
//   advance    enable for every switch-stage register (0 = hold)
//   ctrl       swap select per stage, ctrl[s] drives stage s
//   row_idx    index of the next row to accept
//   busy       sequencer is not idle
//   done       one-cycle pulse when the final row leaves the output
// Build option
//   BACK_TO_BACK_EN : when defined, a new matrix may start on the last
//                     accept of the current one or at any time during its
//                     drain, overlapping the drain with the next load.
// ============================================================================
module transpose_network_sequencer #(
  parameter int N_ROWS    = 4,
  parameter int STAGES    = 2,
  parameter int STAGE_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_last,
  output logic                      advance,
  output logic [STAGES-1:0]         ctrl,
  output logic [$clog2(N_ROWS)-1:0] row_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int            IW       = $clog2(N_ROWS);
  localparam int            L        = STAGES * STAGE_LAT;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_row_idx;

  // Shadow of the switch network: register k carries the {valid, row index}
  // of the beat currently held in network register k (k = 1..L).
  logic          r_pv [1:L];
  logic [IW-1:0] r_pi [1:L];

  // Slot view: slot 0 is the beat being accepted this cycle, slot k>0 is
  // the beat held in register k.
  logic          w_slot_v [0:L-1];
  logic [IW-1:0] w_slot_i [0:L-1];

  logic w_stall;
  logic w_in_fire;
  logic w_mid_busy;
  logic w_drain_empty;

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  // A beat sitting in the output register that the sink refuses freezes the
  // whole network, including the source side.
  assign w_stall   = r_pv[L] & ~out_ready;
  assign advance   = ~w_stall;
  assign in_ready  = (r_state == S_LOAD) & ~w_stall;
  assign w_in_fire = in_valid & in_ready;

  always_comb begin
    w_slot_v[0] = w_in_fire;
    w_slot_i[0] = r_row_idx;
    for (int k = 1; k < L; k++) begin
      w_slot_v[k] = r_pv[k];
      w_slot_i[k] = r_pi[k];
    end
  end

  // Any valid beat still travelling through the network before the output
  // register keeps the drain open.
  always_comb begin
    w_mid_busy = 1'b0;
    for (int k = 1; k < L; k++) begin
      w_mid_busy = w_mid_busy | r_pv[k];
    end
  end

  // After this edge the network is empty: nothing upstream of the output
  // register, and the output beat (if any) is being taken.
  assign w_drain_empty = ~w_mid_busy & ~w_stall;

  // --------------------------------------------------------------------------
  // Swap selects: stage s swaps on bit s of the row index of the beat that
  // enters its register. Stage 0 sees the beat being accepted right now, so
  // its select is combinational from the handshake.
  // --------------------------------------------------------------------------
  for (genvar s = 0; s < STAGES; s++) begin : g_ctrl
    assign ctrl[s] = w_slot_v[s*STAGE_LAT] & w_slot_i[s*STAGE_LAT][s];
  end

  // --------------------------------------------------------------------------
  // Output side
  // --------------------------------------------------------------------------
  assign out_valid = r_pv[L];
  assign out_last  = r_pv[L] & (r_pi[L] == LAST_IDX);
  assign done      = out_valid & out_ready & out_last;
  assign busy      = (r_state != S_IDLE);
  assign row_idx   = r_row_idx;

  // --------------------------------------------------------------------------
  // Valid / index shift register, moves in lock-step with the network.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= L; k++) begin
        r_pv[k] <= 1'b0;
        r_pi[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 1; k <= L; k++) begin
        r_pv[k] <= w_slot_v[k-1];
        r_pi[k] <= w_slot_i[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM and accept counter. row_idx only moves on an accept, and
  // no accept can happen during a stall, so it holds automatically then.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_row_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_LOAD;
            r_row_idx <= '0;
          end
        end

        S_LOAD: begin
          if (w_in_fire) begin
            if (r_row_idx == LAST_IDX) begin
              r_row_idx <= '0;
`ifdef BACK_TO_BACK_EN
              // A start seen with the final row chains straight into the
              // next matrix; the current one drains underneath it.
              r_state   <= start ? S_LOAD : S_DRAIN;
`else
              r_state   <= S_DRAIN;
`endif
            end else begin
              r_row_idx <= r_row_idx + IW'(1);
            end
          end
        end

        S_DRAIN: begin
`ifdef BACK_TO_BACK_EN
          if (start) begin
            r_state   <= S_LOAD;
            r_row_idx <= '0;
          end else if (w_drain_empty) begin
            r_state   <= S_IDLE;
          end
`else
          // A start arriving together with the final handshake is dropped.
          if (w_drain_empty) begin
            r_state <= S_IDLE;
          end
`endif
        end

        default: begin
          r_state   <= S_IDLE;
          r_row_idx <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transpose_network_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_transpose_network_sequencer
// Purpose  : Self-checking bench for transpose_network_sequencer
//            (N_ROWS=4, STAGES=2, STAGE_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_transpose_network_sequencer;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int SL = 1;
  localparam int L  = S * SL;
`ifdef BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_DRAIN = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic         out_ready;
  logic         out_valid;
  logic         out_last;
  logic         advance;
  logic [S-1:0] ctrl;
  logic [1:0]   row_idx;
  logic         busy;
  logic         done;

  transpose_network_sequencer #(
    .N_ROWS    (N),
    .STAGES    (S),
    .STAGE_LAT (SL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .advance   (advance),
    .ctrl      (ctrl),
    .row_idx   (row_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks        = 0;
  int failures      = 0;
  int cyc           = 0;
  int dcount        = 0;
  int last_done_cyc = -1;
  int prev_done_cyc = -1;

  // Reference model: a queue of beats in flight, each with its distance
  // from the network input; the beat at distance L is in the output register.
  typedef struct {
    int idx;
    int pos;
  } beat_t;
  beat_t q[$];
  int    m_state;
  int    m_row;

  logic         e_ov, e_last, e_stall, e_ir, e_fire, e_done, e_busy, e_adv;
  logic [S-1:0] e_ctrl;
  logic [1:0]   e_row;

  typedef struct packed {
    logic       st, iv, orr;
    logic       ir, ov, ol, adv, bsy, dn;
    logic [1:0] ctl;
    logic [1:0] row;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, want);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = M_IDLE;
    m_row   = 0;
  endtask

  task automatic model_check();
    e_ov    = (q.size() > 0) && (q[0].pos == L);
    e_last  = e_ov && (q[0].idx == N - 1);
    e_stall = e_ov && !out_ready;
    e_adv   = !e_stall;
    e_ir    = (m_state == M_LOAD) && !e_stall;
    e_fire  = in_valid && e_ir;
    e_done  = e_ov && out_ready && e_last;
    e_busy  = (m_state != M_IDLE);
    e_row   = 2'(m_row);
    for (int s = 0; s < S; s++) begin
      e_ctrl[s] = 1'b0;
      if (s * SL == 0) begin
        e_ctrl[s] = e_fire && (((m_row >> s) & 1) != 0);
      end else begin
        foreach (q[i]) begin
          if (q[i].pos == s * SL) e_ctrl[s] = (((q[i].idx >> s) & 1) != 0);
        end
      end
    end
    chk("in_ready",  32'(in_ready),  32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_last",  32'(out_last),  32'(e_last));
    chk("advance",   32'(advance),   32'(e_adv));
    chk("ctrl",      32'(ctrl),      32'(e_ctrl));
    chk("row_idx",   32'(row_idx),   32'(e_row));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("done",      32'(done),      32'(e_done));
    if (done === 1'b1) begin
      dcount++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
  endtask

  task automatic model_update();
    if (!e_stall) begin
      if (q.size() > 0 && q[0].pos == L) q.delete(0);
      foreach (q[i]) q[i].pos++;
      if (e_fire) q.push_back('{idx: m_row, pos: 1});
    end
    case (m_state)
      M_IDLE: begin
        if (start) begin
          m_state = M_LOAD;
          m_row   = 0;
        end
      end
      M_LOAD: begin
        if (e_fire) begin
          if (m_row == N - 1) begin
            m_row   = 0;
            m_state = (B2B && start) ? M_LOAD : M_DRAIN;
          end else begin
            m_row = m_row + 1;
          end
        end
      end
      default: begin
        if (B2B && start) begin
          m_state = M_LOAD;
          m_row   = 0;
        end else if (q.size() == 0) begin
          m_state = M_IDLE;
        end
      end
    endcase
    cyc++;
  endtask

  task automatic drive_check(input logic st, input logic iv, input logic orr);
    @(negedge clk);
    start     = st;
    in_valid  = iv;
    out_ready = orr;
    #1;
    model_check();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
  endtask

  task automatic cycle(input logic st, input logic iv, input logic orr);
    drive_check(st, iv, orr);
    commit();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_ctrl"},      32'(ctrl),      32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_advance"},   32'(advance),   32'd1);
    chk({tag, "_row_idx"},   32'(row_idx),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;

    // Fields: st iv or | in_ready out_valid out_last advance busy done | ctrl | row_idx
    // Basic matrix, no stalls.
    tbl.push_back(vec_t'(13'b101_000100_00_00));
    tbl.push_back(vec_t'(13'b011_100110_00_00));
    tbl.push_back(vec_t'(13'b011_100110_01_01));
    tbl.push_back(vec_t'(13'b011_110110_00_10));
    tbl.push_back(vec_t'(13'b011_110110_11_11));
    tbl.push_back(vec_t'(13'b001_010110_10_00));
    tbl.push_back(vec_t'(13'b001_011111_00_00));
    tbl.push_back(vec_t'(13'b001_000100_00_00));
    // Sink refuses the first output row for three cycles.
    tbl.push_back(vec_t'(13'b101_000100_00_00));
    tbl.push_back(vec_t'(13'b011_100110_00_00));
    tbl.push_back(vec_t'(13'b011_100110_01_01));
    tbl.push_back(vec_t'(13'b010_010010_00_10));
    tbl.push_back(vec_t'(13'b010_010010_00_10));
    tbl.push_back(vec_t'(13'b010_010010_00_10));
    tbl.push_back(vec_t'(13'b011_110110_00_10));
    tbl.push_back(vec_t'(13'b011_110110_11_11));
    tbl.push_back(vec_t'(13'b001_010110_10_00));
    tbl.push_back(vec_t'(13'b001_011111_00_00));
    tbl.push_back(vec_t'(13'b001_000100_00_00));

    rst_n     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive_check(tbl[i].st, tbl[i].iv, tbl[i].orr);
      chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_last", i),  32'(out_last),  32'(tbl[i].ol));
      chk($sformatf("tbl%0d_advance", i),   32'(advance),   32'(tbl[i].adv));
      chk($sformatf("tbl%0d_busy", i),      32'(busy),      32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_done", i),      32'(done),      32'(tbl[i].dn));
      chk($sformatf("tbl%0d_ctrl", i),      32'(ctrl),      32'(tbl[i].ctl));
      chk($sformatf("tbl%0d_row_idx", i),   32'(row_idx),   32'(tbl[i].row));
      commit();
    end

    // Input bubbles 1,0,1,0,1,1
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    drive_check(1'b0, 1'b0, 1'b1);
    chk("bubble_row_wrap", 32'(row_idx), 32'd0);
    commit();
    repeat (3) cycle(1'b0, 1'b0, 1'b1);

    // Start pulsed mid-load is ignored: exactly one done for the matrix
    d0 = dcount;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    chk("ignored_start_dones", 32'(dcount - d0), 32'd1);
    chk("ignored_start_idle",  32'(busy),        32'd0);

`ifdef BACK_TO_BACK_EN
    // Second matrix chained on the fourth accept of the first
    d0 = dcount;
    cycle(1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    drive_check(1'b0, 1'b1, 1'b1);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    commit();
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b1);
    chk("b2b_dones",   32'(dcount - d0),                    32'd2);
    chk("b2b_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd4);
`endif

    // Reset in the middle of a load after two rows
    d0 = dcount;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    chk("midrst_no_done", 32'(dcount - d0), 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 3) != 0));
    end
    repeat (12) cycle(1'b0, 1'b1, 1'b1);
    repeat (8)  cycle(1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
